// File: rtl/truth_table_sweeper_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg: shared definitions for the truth_table_sweeper block.
//   tt_state_e : sweep FSM state (IDLE / RUN / DONE)
//   SIG_W      : width of the optional row signature
//   SIG_POLY   : CRC-8 polynomial used by the optional row signature
//   rows_of(n) : number of truth-table rows for an n-input function
// The signature feature is compiled in with the TT_SIGNATURE_EN macro.
// ---------------------------------------------------------------------------
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    localparam int          SIG_W    = 8;
    localparam logic [7:0]  SIG_POLY = 8'h07;

    function automatic int rows_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if: row output stream of the truth-table sweeper.
//   row_valid : producer presents a row
//   row_ready : consumer can take the row
//   row_in    : input combination of the row (MSB = first variable)
//   row_out   : function value for row_in
//   row_last  : row is the final row of the sweep
// Handshake: a row transfers on every rising clk edge where row_valid and
// row_ready are both high. While row_valid is high and row_ready is low,
// row_in/row_out/row_last hold steady; row_valid never depends on row_ready.
// Modports: master = sweeper (producer), slave = consumer.
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    logic            row_valid;
    logic            row_ready;
    logic [N_IN-1:0] row_in;
    logic            row_out;
    logic            row_last;

    modport master (
        output row_valid,
        output row_in,
        output row_out,
        output row_last,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_in,
        input  row_out,
        input  row_last,
        output row_ready
    );
endinterface

// File: rtl/truth_table_sweeper_row_counter.sv
// ---------------------------------------------------------------------------
// tt_row_counter: N_IN-bit up/down row index for the sweeper.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : start a sweep; captures load_dir and sets the first index
//   load_dir  : 0 = ascending from 0, 1 = descending from all-ones
//   en        : step one row in the captured direction
//   idx       : current row index
//   last      : idx is the final row for the captured direction
// The owner never asserts en on the last row, so the index never wraps.
// ---------------------------------------------------------------------------
module tt_row_counter #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            load_dir,
    input  logic            en,
    output logic [N_IN-1:0] idx,
    output logic            last
);
    logic dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            dir_q <= load_dir;
            idx   <= load_dir ? '1 : '0;
        end else if (en) begin
            idx   <= dir_q ? idx - N_IN'(1) : idx + N_IN'(1);
        end
    end

    assign last = dir_q ? (idx == '0) : (idx == '1);

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper: sweeps all 2**N_IN rows of a Boolean function given
// as a mask, emitting one row per valid/ready beat and counting true rows.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a sweep (only honoured in IDLE)
//   abort      : stop a running sweep, no done pulse, partial count kept
//   dir        : 0 ascending, 1 descending; captured at start
//   func_mask  : bit i = f(row i); captured at start
//   row        : row stream (truth_table_sweeper_if master modport)
//   busy       : high in RUN and DONE
//   done       : one-cycle completion pulse
//   ones_cnt   : accepted rows with row_out = 1
//   state_dbg  : current FSM state
//   sig        : CRC-8 of accepted row_out bits (only with TT_SIGNATURE_EN)
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      dir,
    input  logic [rows_of(N_IN)-1:0]  func_mask,
    truth_table_sweeper_if.master     row,
    output logic                      busy,
    output logic                      done,
    output logic [N_IN:0]             ones_cnt,
    output tt_state_e                 state_dbg
`ifdef TT_SIGNATURE_EN
    ,
    output logic [SIG_W-1:0]          sig
`endif
);
    localparam int ROWS = rows_of(N_IN);

    tt_state_e       state, state_n;
    logic [ROWS-1:0] mask_q;
    logic [N_IN-1:0] row_idx;
    logic            idx_last;
    logic            load;
    logic            step;
    logic            accept;

    tt_row_counter #(
        .N_IN (N_IN)
    ) u_row_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_dir (dir),
        .en       (step),
        .idx      (row_idx),
        .last     (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // abort outranks the handshake, so an aborted beat is never accepted.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (row.row_ready) begin
                    accept = 1'b1;
                    if (idx_last) begin
                        state_n = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (load) begin
            mask_q <= func_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (load) begin
            ones_cnt <= '0;
        end else if (accept) begin
            ones_cnt <= ones_cnt + {{N_IN{1'b0}}, row.row_out};
        end
    end

`ifdef TT_SIGNATURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= '0;
        end else if (accept) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^
                   ((sig[SIG_W-1] ^ row.row_out) ? SIG_POLY : 8'h00);
        end
    end
`endif

    // row_in/row_out come straight from the index register and captured
    // mask, so they cannot move while the counter is not stepping.
    assign row.row_valid = (state == RUN);
    assign row.row_in    = row_idx;
    assign row.row_out   = mask_q[row_idx];
    assign row.row_last  = (state == RUN) && idx_last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper: self-checking bench for truth_table_sweeper.
// Main instance N_IN=3, second instance N_IN=1. Expected rows come from the
// mask and direction alone (row list in exp_q), true-row counts from
// $countones, signatures from a bit-serial CRC over accepted row values.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;
    import tt_pkg::*;

    localparam int N_IN = 3;
    localparam int ROWS = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (N_IN = 3) ----------------
    logic            start, abort, dir;
    logic [ROWS-1:0] func_mask;
    logic            busy, done;
    logic [N_IN:0]   ones_cnt;
    tt_state_e       state_dbg;
`ifdef TT_SIGNATURE_EN
    logic [7:0]      sig;
`endif
    truth_table_sweeper_if #(.N_IN(N_IN)) row_if();

    truth_table_sweeper #(.N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .dir       (dir),
        .func_mask (func_mask),
        .row       (row_if),
        .busy      (busy),
        .done      (done),
        .ones_cnt  (ones_cnt),
        .state_dbg (state_dbg)
`ifdef TT_SIGNATURE_EN
        ,
        .sig       (sig)
`endif
    );

    // ---------------- DUT (N_IN = 1) ----------------
    logic       start1, abort1, dir1;
    logic [1:0] mask1;
    logic       busy1, done1;
    logic [1:0] ones1;
    tt_state_e  state1;
`ifdef TT_SIGNATURE_EN
    logic [7:0] sig1;
`endif
    truth_table_sweeper_if #(.N_IN(1)) row1_if();

    truth_table_sweeper #(.N_IN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .abort     (abort1),
        .dir       (dir1),
        .func_mask (mask1),
        .row       (row1_if),
        .busy      (busy1),
        .done      (done1),
        .ones_cnt  (ones1),
        .state_dbg (state1)
`ifdef TT_SIGNATURE_EN
        ,
        .sig       (sig1)
`endif
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [N_IN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] s, input logic b);
        return {s[6:0], 1'b0} ^ ((s[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready
    // abort_after: abort on the beat after this many accepted rows (-1 none)
    task automatic run_sweep(input logic [7:0] mask, input logic d, input int mode,
                             input int abort_after, input logic abort_at_start);
        int         accepted;
        int         cyc;
        int         ones_exp;
        logic [7:0] crc_exp;
        logic [N_IN-1:0] r;
        accepted = 0;
        cyc      = 0;
        ones_exp = 0;
        crc_exp  = 8'h00;
        exp_q.delete();
        for (int k = 0; k < ROWS; k++) exp_q.push_back(N_IN'(d ? ROWS - 1 - k : k));

        start     = 1'b1;
        abort     = abort_at_start;
        func_mask = mask;
        dir       = d;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("first_count_cleared", 32'(ones_cnt), 32'd0);

        while (exp_q.size() > 0 && cyc < 400) begin
            r = exp_q[0];
            check("row_valid", 32'(row_if.row_valid), 32'd1);
            check("row_in",    32'(row_if.row_in),    32'(r));
            check("row_out",   32'(row_if.row_out),   32'(mask[r]));
            check("row_last",  32'(row_if.row_last),  32'(exp_q.size() == 1));
            check("busy_run",  32'(busy),             32'd1);
            check("done_run",  32'(done),             32'd0);

            case (mode)
                0:       row_if.row_ready = 1'b1;
                1:       row_if.row_ready = (cyc % 3 == 0);
                default: row_if.row_ready = 1'($urandom_range(0, 1));
            endcase
            // Mid-sweep noise: mask, dir and start must all be ignored now.
            func_mask = 8'($urandom);
            dir       = 1'($urandom_range(0, 1));
            start     = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;

            if (abort_after >= 0 && accepted == abort_after) begin
                row_if.row_ready = 1'b1;
                abort            = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                check("abort_busy",  32'(busy),             32'd0);
                check("abort_valid", 32'(row_if.row_valid), 32'd0);
                check("abort_done",  32'(done),             32'd0);
                check("abort_count", 32'(ones_cnt),         32'(ones_exp));
`ifdef TT_SIGNATURE_EN
                check("abort_sig",   32'(sig),              32'(crc_exp));
`endif
                tick();
                check("abort_no_done", 32'(done),     32'd0);
                check("abort_hold",    32'(ones_cnt), 32'(ones_exp));
                return;
            end

            if (row_if.row_ready) begin
                ones_exp += int'(mask[r]);
                crc_exp   = crc_step(crc_exp, mask[r]);
                void'(exp_q.pop_front());
                accepted++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("sweep_timeout", 32'(exp_q.size()), 32'd0);

        check("done_pulse", 32'(done),             32'd1);
        check("done_busy",  32'(busy),             32'd1);
        check("done_valid", 32'(row_if.row_valid), 32'd0);
        check("done_count", 32'(ones_cnt),         32'($countones(mask)));
        tick();
        check("done_clear", 32'(done),     32'd0);
        check("idle_busy",  32'(busy),     32'd0);
        check("idle_count", 32'(ones_cnt), 32'($countones(mask)));
`ifdef TT_SIGNATURE_EN
        check("sig_final",  32'(sig),      32'(crc_exp));
`endif
    endtask

    // ---------------- safety timeout ----------------
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        start = 0; abort = 0; dir = 0; func_mask = '0; row_if.row_ready = 1'b0;
        start1 = 0; abort1 = 0; dir1 = 0; mask1 = '0; row1_if.row_ready = 1'b0;

        #12;
        check("rst_valid", 32'(row_if.row_valid), 32'd0);
        check("rst_row_in", 32'(row_if.row_in),   32'd0);
        check("rst_row_out", 32'(row_if.row_out), 32'd0);
        check("rst_last",  32'(row_if.row_last),  32'd0);
        check("rst_busy",  32'(busy),             32'd0);
        check("rst_done",  32'(done),             32'd0);
        check("rst_count", 32'(ones_cnt),         32'd0);
        check("rst_state", 32'(state_dbg),        32'(IDLE));
`ifdef TT_SIGNATURE_EN
        check("rst_sig",   32'(sig),              32'd0);
`endif
        rst = 1'b0;
        tick();

        // Directed sweeps with mask (~a|b)&(b|~c)
        run_sweep(8'hCD, 1'b0, 0, -1, 1'b0);
        run_sweep(8'hCD, 1'b1, 0, -1, 1'b0);
        run_sweep(8'hCD, 1'b0, 1, -1, 1'b0);
        run_sweep(8'hCD, 1'b0, 0, 3, 1'b0);
        run_sweep(8'hCD, 1'b0, 0, -1, 1'b0);
        // start and abort together in IDLE: start wins
        run_sweep(8'hFF, 1'b0, 0, -1, 1'b1);
        run_sweep(8'h00, 1'b1, 1, -1, 1'b0);

        // Asynchronous reset between clock edges during RUN
        start = 1'b1; func_mask = 8'hFF; dir = 1'b0; row_if.row_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_count", 32'(ones_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(row_if.row_valid), 32'd0);
        check("arst_row_in", 32'(row_if.row_in),    32'd0);
        check("arst_row_out", 32'(row_if.row_out),  32'd0);
        check("arst_last",   32'(row_if.row_last),  32'd0);
        check("arst_busy",   32'(busy),             32'd0);
        check("arst_done",   32'(done),             32'd0);
        check("arst_count",  32'(ones_cnt),         32'd0);
        rst = 1'b0;
        row_if.row_ready = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Randomized sweeps, some aborted
        for (int n = 0; n < 8; n++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROWS - 1)) : -1;
            run_sweep(8'($urandom), 1'($urandom_range(0, 1)), 2, ab, 1'b0);
        end

        // N_IN = 1 instance, ascending then descending, mask 2'b10
        start1 = 1'b1; mask1 = 2'b10; dir1 = 1'b0; row1_if.row_ready = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_r0_valid", 32'(row1_if.row_valid), 32'd1);
        check("n1_r0_in",    32'(row1_if.row_in),    32'd0);
        check("n1_r0_out",   32'(row1_if.row_out),   32'd0);
        check("n1_r0_last",  32'(row1_if.row_last),  32'd0);
        tick();
        check("n1_r1_in",    32'(row1_if.row_in),    32'd1);
        check("n1_r1_out",   32'(row1_if.row_out),   32'd1);
        check("n1_r1_last",  32'(row1_if.row_last),  32'd1);
        tick();
        check("n1_done",     32'(done1),             32'd1);
        check("n1_count",    32'(ones1),             32'd1);
`ifdef TT_SIGNATURE_EN
        check("n1_sig",      32'(sig1),              32'h07);
`endif
        tick();
        check("n1_done_clr", 32'(done1),             32'd0);

        start1 = 1'b1; dir1 = 1'b1; mask1 = 2'b11;
        tick();
        start1 = 1'b0;
        check("n1d_r0_in",   32'(row1_if.row_in),    32'd1);
        check("n1d_r0_last", 32'(row1_if.row_last),  32'd0);
        tick();
        check("n1d_r1_in",   32'(row1_if.row_in),    32'd0);
        check("n1d_r1_last", 32'(row1_if.row_last),  32'd1);
        tick();
        check("n1d_done",    32'(done1),             32'd1);
        check("n1d_count",   32'(ones1),             32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
